mont_mult_arbiter: RTL and testbench
====================================

# mont_mult_arbiter

Shares one Montgomery multiplier core between two requesters (e.g. the square and multiply paths of the exponentiation controller, or two exponentiation engines). It queues start pulses, grants the multiplier to one requester at a time, and drives the multiplier's start/operand interface. It returns each result with a one-cycle done pulse to the requester that issued it.

## Interface
- `WIDTH`, 512, operand/result width in bits.

- `clk`  in  1  clock, all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reqN_start` (N=0,1)  in  1  one-cycle request pulse.
- `reqN_a`, `reqN_b`, `reqN_m`  in  WIDTH  operands; held stable from `reqN_start` until `reqN_done`.
- `reqN_busy`  out  1  request pending or in service.
- `reqN_done`  out  1  one-cycle result pulse.
- `reqN_res`  out  WIDTH  registered result; holds until the next `reqN_done` for the same N.
- `mult_start`  out  1  one-cycle start to the multiplier.
- `mult_a`, `mult_b`, `mult_m`  out  WIDTH  registered operands to the multiplier.
- `mult_done`  in  1  one-cycle completion from the multiplier.
- `mult_res`  in  WIDTH  multiplier result, valid with `mult_done`.

## Operation
- Pending bits `pend0` and `pend1`:
  - Set on `reqN_start` when `reqN_busy`=0.
  - A start while busy is ignored; there is no queueing beyond one request per requester.
- `reqN_busy` = `pendN` OR (`grant`==N AND state in {ISSUE, WAIT}).
- FSM states: IDLE, ISSUE, WAIT, RETURN.
  - IDLE: if any `pend` bit is set, select `grant` and latch that requester's a/b/m into `mult_a/b/m`, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `mult_start`=1 for exactly one cycle, then go to WAIT.
  - WAIT: on `mult_done`, latch `mult_res` into `reqN_res[grant]`, clear `pend[grant]`, then go to RETURN.
  - RETURN: `reqN_done[grant]`=1 for exactly one cycle, then go to IDLE.
- Arbitration is selected by `MONT_ARB_RR_EN` (see Configuration). `last_grant` updates when IDLE leaves to ISSUE.
- `mult_done` outside WAIT is ignored.
- A start in the same cycle as that requester's own `reqN_done` is accepted, because `pend` was already cleared.
- A start from the non-granted requester during ISSUE, WAIT or RETURN only sets its `pend` bit.
- Reset values:
  - State IDLE; `pend0`=`pend1`=0; `last_grant`=1.
  - All outputs 0, including `mult_a/b/m` and `reqN_res`.
- Reset mid-operation aborts the transaction with no done pulse. The multiplier shares the same `reset`.

## Timing
- `reqN_start` in cycle t → `pendN`=1 in t+1 → ISSUE (`mult_start`=1, operands valid) in t+2 when the arbiter was IDLE.
- `mult_done` in cycle d → `reqN_done`=1 and `reqN_res` valid in d+1 → IDLE in d+2.
- A queued request from the other requester sees `mult_start` at d+3.
- Total overhead: 3 cycles plus multiplier latency.
- `mult_a/b/m` stay constant from ISSUE through WAIT.

## Configuration
- `MONT_ARB_RR_EN` defined: round-robin.
  - If both pend bits are set, grant the requester that is not `last_grant`.
  - A single pending requester is always granted.
- `MONT_ARB_RR_EN` undefined: fixed priority; requester 0 wins whenever `pend0`=1.
  - `last_grant` is still maintained but unused.

## Test plan
- Single request:
  - Stimulus: `req0_start` with a=3, b=5, m=13 (WIDTH=512); behavioural model returns `mult_done` 10 cycles after `mult_start` with res=(a·b·R⁻¹ mod m).
  - Required: `mult_start` exactly 2 cycles after start; `req0_done` 1 cycle after `mult_done` with matching `req0_res`; `req1_done` never pulses.
- Simultaneous starts:
  - With RR: req0 is served first (`last_grant` reset = 1), then req1; `mult_start` pulses 3 cycles after the first `mult_done`.
  - Without RR: same order.
- Starvation check, req0 re-requesting on every `req0_done` while req1 is pending:
  - With RR: grants alternate 0, 1, 0, 1.
  - Without RR: req1 is never served.
- Start while busy: a second `req0_start` during WAIT is ignored, giving exactly one `req0_done`.
- Start on done cycle: `req0_start` coincident with `req0_done` is accepted; new `mult_start` appears 2 cycles later.
- Reset mid-WAIT: assert `reset` during WAIT → all outputs 0 and both busy signals 0 immediately; no done pulse; a later request completes normally.

Source files
------------

// File: rtl/mont_mult_arbiter.sv
// Two-requester arbiter in front of a shared Montgomery multiplier core.
// Define MONT_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mont_mult_arbiter #(
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_start,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req0_m,
    output logic             req0_busy,
    output logic             req0_done,
    output logic [WIDTH-1:0] req0_res,
    input  logic             req1_start,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] req1_m,
    output logic             req1_busy,
    output logic             req1_done,
    output logic [WIDTH-1:0] req1_res,
    output logic             mult_start,
    output logic [WIDTH-1:0] mult_a,
    output logic [WIDTH-1:0] mult_b,
    output logic [WIDTH-1:0] mult_m,
    input  logic             mult_done,
    input  logic [WIDTH-1:0] mult_res
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StReturn} state_t;

    state_t state;
    logic   pend0;
    logic   pend1;
    logic   grant;
    logic   last_grant;
    logic   in_service;
    logic   pick;

    assign in_service = (state == StIssue) || (state == StWait);
    assign req0_busy  = pend0 | (~grant & in_service);
    assign req1_busy  = pend1 | (grant & in_service);

    // Requester chosen in IDLE; only meaningful when a pend bit is set.
    always_comb begin
        pick = 1'b0;
`ifdef MONT_ARB_RR_EN
        if (pend0 && pend1) begin
            pick = ~last_grant;
        end else begin
            pick = pend1;
        end
`else
        pick = ~pend0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            pend0      <= 1'b0;
            pend1      <= 1'b0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            mult_m     <= '0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_res   <= '0;
            req1_res   <= '0;
        end else begin
            mult_start <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            if (req0_start && !req0_busy) begin
                pend0 <= 1'b1;
            end
            if (req1_start && !req1_busy) begin
                pend1 <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (pend0 || pend1) begin
                        grant      <= pick;
                        last_grant <= pick;
                        mult_a     <= pick ? req1_a : req0_a;
                        mult_b     <= pick ? req1_b : req0_b;
                        mult_m     <= pick ? req1_m : req0_m;
                        mult_start <= 1'b1;
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    state <= StWait;
                end
                StWait: begin
                    if (mult_done) begin
                        // The granted requester is busy here, so no set can collide with this clear.
                        if (grant) begin
                            req1_res  <= mult_res;
                            pend1     <= 1'b0;
                            req1_done <= 1'b1;
                        end else begin
                            req0_res  <= mult_res;
                            pend0     <= 1'b0;
                            req0_done <= 1'b1;
                        end
                        state <= StReturn;
                    end
                end
                StReturn: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mult_arbiter.sv
// Scoreboard bench for mont_mult_arbiter with a 10-cycle behavioural Montgomery multiplier.
module tb_mont_mult_arbiter;

    localparam int W = 512;

    typedef struct {
        bit           id;
        logic [W-1:0] res;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_start = 1'b0, req1_start = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req0_m = '0;
    logic [W-1:0] req1_a = '0, req1_b = '0, req1_m = '0;
    logic         req0_busy, req1_busy, req0_done, req1_done;
    logic [W-1:0] req0_res, req1_res;
    logic         mult_start;
    logic [W-1:0] mult_a, mult_b, mult_m;
    logic         mult_done = 1'b0;
    logic [W-1:0] mult_res = '0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   ms_q[$];
    int   dn_q[$];

    mont_mult_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_start (req0_start),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_m     (req0_m),
        .req0_busy  (req0_busy),
        .req0_done  (req0_done),
        .req0_res   (req0_res),
        .req1_start (req1_start),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_m     (req1_m),
        .req1_busy  (req1_busy),
        .req1_done  (req1_done),
        .req1_res   (req1_res),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_m     (mult_m),
        .mult_done  (mult_done),
        .mult_res   (mult_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Radix-2 Montgomery product a*b*2^-W mod m (m odd, a,b < m).
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    // Behavioural multiplier: done 10 cycles after start, aborted by reset.
    initial begin
        int           mcnt;
        logic [W-1:0] ma, mb, mm;
        mcnt = 0;
        ma = '0;
        mb = '0;
        mm = '0;
        forever begin
            @(negedge clk);
            mult_done = 1'b0;
            if (reset) begin
                mcnt = 0;
            end else begin
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        mult_done = 1'b1;
                        mult_res  = mont(ma, mb, mm);
                    end
                end
                if (mult_start) begin
                    mcnt = 10;
                    ma = mult_a;
                    mb = mult_b;
                    mm = mult_m;
                end
            end
        end
    end

    task automatic got_done(input bit id, input logic [W-1:0] res);
        exp_t e;
        dn_q.push_back(cyc);
        if (exp_q.size() == 0) begin
            check_int("unexpected_done_id", int'(id), -1);
        end else begin
            e = exp_q.pop_front();
            check_int("done_id", int'(id), int'(e.id));
            check_val("done_res", res, e.res);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mult_start) ms_q.push_back(cyc);
            if (req0_done) got_done(1'b0, req0_res);
            if (req1_done) got_done(1'b1, req1_res);
        end
    end

    task automatic expect_done(input bit id, input int res);
        exp_t e;
        e.id  = id;
        e.res = W'(res);
        exp_q.push_back(e);
    endtask

    task automatic issue(input bit id, input int a, input int b, input int m);
        if (id) begin
            req1_a = W'(a);
            req1_b = W'(b);
            req1_m = W'(m);
            req1_start = 1'b1;
        end else begin
            req0_a = W'(a);
            req0_b = W'(b);
            req0_m = W'(m);
            req0_start = 1'b1;
        end
    endtask

    task automatic end_pulse();
        @(negedge clk);
        req0_start = 1'b0;
        req1_start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req0_busy || req1_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_int("drain_in_budget", int'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    function automatic int at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1000;
    endfunction

    task automatic clear_stamps();
        ms_q.delete();
        dn_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_int({tag, "_busy0"}, int'(req0_busy), 0);
        check_int({tag, "_busy1"}, int'(req1_busy), 0);
        check_int({tag, "_done0"}, int'(req0_done), 0);
        check_int({tag, "_done1"}, int'(req1_done), 0);
        check_int({tag, "_mstart"}, int'(mult_start), 0);
        check_val({tag, "_mult_a"}, mult_a, '0);
        check_val({tag, "_mult_b"}, mult_b, '0);
        check_val({tag, "_mult_m"}, mult_m, '0);
        check_val({tag, "_res0"}, req0_res, '0);
        check_val({tag, "_res1"}, req1_res, '0);
    endtask

`ifdef MONT_ARB_RR_EN
    int starve_order[6] = '{0, 1, 0, 1, 0, 0};
`else
    int starve_order[6] = '{0, 0, 0, 0, 1, 1};
`endif

    initial begin
        int t;
        int r;
        int n;
        int ndone;
        int r0;
        int r1;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single request: 3*5*R^-1 mod 13 = 6
        clear_stamps();
        t = cyc;
        issue(1'b0, 3, 5, 13);
        expect_done(1'b0, 6);
        end_pulse();
        drain(100);
        check_int("single_nstart", ms_q.size(), 1);
        check_int("single_start_lat", at(ms_q, 0) - t, 2);
        check_int("single_done_lat", at(dn_q, 0) - at(ms_q, 0), 11);

        // Simultaneous starts: req0 first in both builds
        clear_stamps();
        t = cyc;
        issue(1'b0, 7, 9, 11);
        issue(1'b1, 2, 6, 7);
        expect_done(1'b0, 2);
        expect_done(1'b1, 3);
        end_pulse();
        drain(200);
        check_int("simul_nstart", ms_q.size(), 2);
        check_int("simul_start_lat", at(ms_q, 0) - t, 2);
        check_int("simul_second_start", at(ms_q, 1) - (at(dn_q, 0) - 1), 3);

        // Starvation: req0 re-requests on its done (3x), req1 on its done (1x)
        clear_stamps();
        issue(1'b0, 3, 5, 13);
        issue(1'b1, 2, 6, 7);
        for (int i = 0; i < 6; i++) expect_done(starve_order[i] != 0, (starve_order[i] != 0) ? 3 : 6);
        r0 = 0;
        r1 = 0;
        ndone = 0;
        n = 0;
        while (ndone < 6 && n < 600) begin
            @(negedge clk);
            n++;
            req0_start = 1'b0;
            req1_start = 1'b0;
            if (req0_done) begin
                ndone++;
                if (r0 < 3) begin
                    req0_start = 1'b1;
                    r0++;
                end
            end
            if (req1_done) begin
                ndone++;
                if (r1 < 1) begin
                    req1_start = 1'b1;
                    r1++;
                end
            end
        end
        end_pulse();
        check_int("starve_ndone", ndone, 6);
        drain(100);

        // Start while busy is ignored: 4*10*R^-1 mod 13 = 3
        clear_stamps();
        issue(1'b0, 4, 10, 13);
        expect_done(1'b0, 3);
        end_pulse();
        repeat (5) @(negedge clk);
        req0_start = 1'b1;
        end_pulse();
        drain(100);
        repeat (5) @(negedge clk);
        check_int("busy_ndone", dn_q.size(), 1);
        check_int("busy_nstart", ms_q.size(), 1);

        // Start on the done cycle is accepted
        clear_stamps();
        issue(1'b0, 3, 5, 13);
        expect_done(1'b0, 6);
        expect_done(1'b0, 3);
        end_pulse();
        n = 0;
        while (!req0_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("ondone_seen", int'(req0_done), 1);
        r = cyc;
        req0_a = W'(4);
        req0_b = W'(10);
        req0_start = 1'b1;
        end_pulse();
        drain(100);
        check_int("ondone_nstart", ms_q.size(), 2);
        check_int("ondone_restart_lat", at(ms_q, 1) - r, 2);

        // Reset during WAIT aborts with no done
        clear_stamps();
        issue(1'b1, 2, 6, 7);
        end_pulse();
        repeat (5) @(negedge clk);
        check_int("pre_reset_busy1", int'(req1_busy), 1);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_int("midreset_ndone", dn_q.size(), 0);
        issue(1'b0, 7, 9, 11);
        expect_done(1'b0, 2);
        end_pulse();
        drain(100);
        check_int("post_reset_ndone", dn_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
